// File: rtl/alu_types.sv
// Command encoding shared by the ALU and every block that drives it.
package alu_types;
    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_AND  = 3'd2,
        CMD_OR   = 3'd3,
        CMD_XOR  = 3'd4,
        CMD_SHL  = 3'd5,
        CMD_SHR  = 3'd6,
        CMD_PASS = 3'd7
    } cmd_t;
endpackage

// File: rtl/ucode_seq_pkg.sv
// Microword layout, opcodes and sequencer states for ucode_seq.
package ucode_types;
    import alu_types::*;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_ALU  = 3'd2,
        OP_JZ   = 3'd3,
        OP_JMP  = 3'd4,
        OP_HALT = 3'd5
    } op_t;

    localparam int RSVD_W = 32 - $bits(op_t) - $bits(cmd_t) - 6 - 16;

    typedef struct packed {
        op_t               op;
        cmd_t              cmd;
        logic [1:0]        dst;
        logic [1:0]        sx;
        logic [1:0]        sy;
        logic [RSVD_W-1:0] rsvd;
        logic [15:0]       imm;
    } uword_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/alu.sv
// Purely combinational 16-bit ALU; arithmetic wraps modulo 2^16.
module alu
    import alu_types::*;
(
    input  cmd_t        i_cmd,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    output logic [15:0] o_z,
    output logic        o_zflag
);
    always_comb begin
        o_z = '0;
        case (i_cmd)
            CMD_ADD:  o_z = i_x + i_y;
            CMD_SUB:  o_z = i_x - i_y;
            CMD_AND:  o_z = i_x & i_y;
            CMD_OR:   o_z = i_x | i_y;
            CMD_XOR:  o_z = i_x ^ i_y;
            CMD_SHL:  o_z = i_x << i_y[3:0];
            CMD_SHR:  o_z = i_x >> i_y[3:0];
            CMD_PASS: o_z = i_x;
            default:  o_z = '0;
        endcase
    end

    assign o_zflag = (o_z == 16'd0);
endmodule

// File: rtl/ucode_ram.sv
// Single-port microprogram store: writes while idle, registered read during fetch.
module ucode_ram
    import ucode_types::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  uword_t                   i_wdata,
    output uword_t                   o_rdata
);
    uword_t r_mem [DEPTH];

    // NOTE: no reset on the array or read register, so this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: fetch/execute loop over ucode_ram driving one alu.
module ucode_seq
    import ucode_types::*;
#(
    parameter  int PROG_DEPTH = 32,
    parameter  int MAX_STEPS  = 1024,
    localparam int AW         = $clog2(PROG_DEPTH),
    localparam int SW         = $clog2(MAX_STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   arg,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  uword_t        prog_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result,
    output logic          zflag_q,
    output logic          fault
);
    state_t        r_state, w_state_next;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_regs [4];
    logic          r_zf;
    logic [SW-1:0] r_steps;
    logic [15:0]   r_result;
    logic          r_fault;

    uword_t        w_ir;
    logic [AW-1:0] w_ram_addr;
    logic          w_accept;
    logic [15:0]   w_alu_z;
    logic          w_alu_zf;
    logic          w_wr_en, w_zf_en, w_halt, w_illegal, w_fault, w_end;
    logic [15:0]   w_wr_data;
    logic [16:0]   w_pc_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_ram_addr = (r_state == S_IDLE) ? prog_addr : r_pc;

    ucode_ram #(.DEPTH(PROG_DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (prog_we && (r_state == S_IDLE)),
        .i_re    (r_state == S_FETCH),
        .i_addr  (w_ram_addr),
        .i_wdata (prog_data),
        .o_rdata (w_ir)
    );

    alu u_alu (
        .i_cmd   (w_ir.cmd),
        .i_x     (r_regs[w_ir.sx]),
        .i_y     (r_regs[w_ir.sy]),
        .o_z     (w_alu_z),
        .o_zflag (w_alu_zf)
    );

    // Decode; the next PC is one bit wider so overrun and bad targets are caught without wrapping.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = w_alu_z;
        w_zf_en   = 1'b0;
        w_halt    = 1'b0;
        w_illegal = 1'b0;
        w_pc_next = 17'(r_pc) + 17'd1;
        case (w_ir.op)
            OP_NOP:  ;
            OP_LDI:  begin w_wr_en = 1'b1; w_wr_data = w_ir.imm; end
            OP_ALU:  begin w_wr_en = 1'b1; w_zf_en = 1'b1; end
            OP_JZ:   if (r_zf) w_pc_next = {1'b0, w_ir.imm};
            OP_JMP:  w_pc_next = {1'b0, w_ir.imm};
            OP_HALT: w_halt = 1'b1;
            default: w_illegal = 1'b1;
        endcase
        // Reserved bits must be zero; anything else decodes as illegal.
        if (w_ir.rsvd != '0) w_illegal = 1'b1;
        w_fault = w_illegal ||
                  (!w_halt && ((w_pc_next >= 17'(PROG_DEPTH)) ||
                               (r_steps == SW'(MAX_STEPS - 1))));
        w_end   = w_halt || w_fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: begin busy = 1'b1; w_state_next = S_EXEC; end
            S_EXEC:  begin busy = 1'b1; w_state_next = w_end ? S_DONE : S_FETCH; end
            S_DONE:  begin done = 1'b1; w_state_next = S_IDLE; end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_zf     <= 1'b0;
            r_steps  <= '0;
            r_result <= '0;
            r_fault  <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (w_accept) begin
            r_pc      <= '0;
            r_zf      <= 1'b0;
            r_steps   <= '0;
            r_fault   <= 1'b0;
            r_regs[0] <= arg;
            for (int i = 1; i < 4; i++) r_regs[i] <= '0;
        end else if (r_state == S_EXEC) begin
            r_steps <= r_steps + 1'b1;
            if (w_wr_en) r_regs[w_ir.dst] <= w_wr_data;
            if (w_zf_en) r_zf <= w_alu_zf;
            if (!w_end)  r_pc <= w_pc_next[AW-1:0];
            if (w_fault) r_fault <= 1'b1;
            if (w_end)   r_result <= (w_wr_en && (w_ir.dst == 2'd0)) ? w_wr_data : r_regs[0];
        end
    end

    assign result  = r_result;
    assign zflag_q = r_zf;
    assign fault   = r_fault;
endmodule
